// File: rtl/hash_intf_pkg.sv
// hash_intf_pkg: shared command/state encodings and config sizing for hash_stream_intf
package hash_intf_pkg;
  typedef enum logic [1:0] {CMD_CONF, CMD_DATA, CMD_RSVD, CMD_ABORT} cmd_t;
  typedef enum logic [2:0] {S_IDLE, S_CONF, S_SER, S_PAD, S_WAIT_HASH, S_RESULT} state_t;
  function automatic int conf_bytes(input int ll_w);
    return 2 + ll_w / 8;
  endfunction
  localparam int CONF_BYTES = conf_bytes(64);
endpackage

// File: rtl/hash_intf_ser.sv
// hash_intf_ser: holds one host beat and emits its bytes one per cycle, byte 0 first
module hash_intf_ser #(
  parameter int BUS_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic                   clr_i,
  input  logic [8*BUS_BYTES-1:0] beat_i,
  output logic                   valid_o,
  output logic                   last_o,
  output logic [7:0]             byte_o
);
  localparam int PW = BUS_BYTES > 1 ? $clog2(BUS_BYTES) : 1;
  logic [8*BUS_BYTES-1:0] beat_q, beat_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic busy_q, busy_d;
  always_comb begin
    valid_o = busy_q;
    last_o = busy_q && ptr_q == PW'(BUS_BYTES - 1);
    byte_o = beat_q[8*ptr_q +: 8];
    beat_d = load_i ? beat_i : beat_q;
    busy_d = clr_i ? 1'b0 : load_i ? 1'b1 : last_o ? 1'b0 : busy_q;
    ptr_d = (clr_i || load_i || last_o) ? '0 : busy_q ? ptr_q + PW'(1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
      ptr_q <= '0;
      busy_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      ptr_q <= ptr_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/hash_stream_intf.sv
// hash_stream_intf: host command decode, block byte serialisation with padding, digest readback
module hash_stream_intf import hash_intf_pkg::*; #(
  parameter int BUS_BYTES   = 1,
  parameter int BLOCK_BYTES = 64,
  parameter int NN_MAX      = 32,
  parameter int LL_W        = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [1:0]                    cmd_i,
  input  logic [8*BUS_BYTES-1:0]        data_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [7:0]                    res_data_o,
  output logic                          res_last_o,
  output logic [6:0]                    kk_o,
  output logic [6:0]                    nn_o,
  output logic [LL_W-1:0]               ll_o,
  output logic                          data_v_o,
  output logic [7:0]                    data_o,
  output logic [$clog2(BLOCK_BYTES)-1:0] data_idx_o,
  output logic                          block_first_o,
  output logic                          block_last_o,
  input  logic                          hash_finished_i,
  input  logic [8*NN_MAX-1:0]           hash_i
);
  localparam int IW = $clog2(BLOCK_BYTES);
  localparam int TW = LL_W + 1;
  localparam int CB = conf_bytes(LL_W);
  state_t state_q, state_d;
  cmd_t cmd;
  logic [7:0] kk_q, kk_d, nn_q, nn_d, cfg_q, cfg_d, rj_q, rj_d, kk_n, nn_n;
  logic [LL_W-1:0] ll_q, ll_d, ll_n;
  logic [TW-1:0] rem_q, rem_d, tot;
  logic [IW-1:0] idx_q, idx_d;
  logic first_q, first_d;
  logic [8*NN_MAX-1:0] dig_q, dig_d;
  logic acc, ser_load, ser_clr, ser_v, ser_last, blk_end;
  logic [7:0] ser_byte;
  assign cmd = cmd_t'(cmd_i);
  assign acc = valid_i && ready_o;
  assign blk_end = idx_q == IW'(BLOCK_BYTES - 1);
  assign ser_load = state_q == S_IDLE && acc && cmd == CMD_DATA && rem_q != '0;
  // Leftover bytes of the beat past the end of the stream are flushed, not sent
  assign ser_clr = state_q == S_SER && ser_v && rem_q == TW'(1);
  hash_intf_ser #(.BUS_BYTES(BUS_BYTES)) u_ser (
    .clk(clk), .reset(reset), .load_i(ser_load), .clr_i(ser_clr), .beat_i(data_i),
    .valid_o(ser_v), .last_o(ser_last), .byte_o(ser_byte)
  );
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    kk_d = kk_q;
    nn_d = nn_q;
    ll_d = ll_q;
    kk_n = kk_q;
    nn_n = nn_q;
    ll_n = ll_q;
    tot = '0;
    cfg_d = cfg_q;
    rem_d = rem_q;
    idx_d = idx_q;
    first_d = first_q;
    dig_d = dig_q;
    rj_d = rj_q;
    case (state_q)
      S_IDLE, S_CONF: if (acc) begin
        if (cmd == CMD_ABORT) begin
          state_d = S_IDLE;
          rem_d = '0;
          idx_d = '0;
          cfg_d = '0;
          first_d = 1'b0;
        end else if (cmd == CMD_CONF) begin
          for (int b = 0; b < BUS_BYTES; b++) begin
            if (int'(cfg_q) + b == 0) kk_n = data_i[8*b +: 8];
            else if (int'(cfg_q) + b == 1) nn_n = data_i[8*b +: 8];
            else if (int'(cfg_q) + b < CB) ll_n[8*(int'(cfg_q) + b - 2) +: 8] = data_i[8*b +: 8];
          end
          kk_d = kk_n;
          nn_d = nn_n;
          ll_d = ll_n;
          cfg_d = cfg_q + 8'(BUS_BYTES);
          state_d = S_CONF;
          if (int'(cfg_q) + BUS_BYTES >= CB) begin
            kk_d = kk_n > 8'(NN_MAX) ? 8'(NN_MAX) : kk_n;
            nn_d = (nn_n == 8'd0 || nn_n > 8'(NN_MAX)) ? 8'(NN_MAX) : nn_n;
            // A nonzero key travels as one zero-padded block ahead of the message
            tot = TW'(ll_n) + ((kk_d != 8'd0) ? TW'(BLOCK_BYTES) : '0);
            rem_d = tot;
            idx_d = '0;
            first_d = 1'b1;
            cfg_d = '0;
            state_d = tot == '0 ? S_PAD : S_IDLE;
          end
        end else if (ser_load) state_d = S_SER;
      end
      S_SER: if (ser_v) begin
        rem_d = rem_q - TW'(1);
        idx_d = idx_q + IW'(1);
        if (blk_end) first_d = 1'b0;
        if (rem_q == TW'(1)) state_d = blk_end ? S_WAIT_HASH : S_PAD;
        else if (ser_last) state_d = S_IDLE;
      end
      S_PAD: begin
        idx_d = idx_q + IW'(1);
        if (blk_end) begin
          first_d = 1'b0;
          state_d = S_WAIT_HASH;
        end
      end
      S_WAIT_HASH: if (hash_finished_i) begin
        for (int j = 0; j < NN_MAX; j++) dig_d[8*j +: 8] = (j < int'(nn_q)) ? hash_i[8*j +: 8] : 8'h00;
        rj_d = '0;
        state_d = S_RESULT;
      end
      S_RESULT: if (res_ready_i) begin
        rj_d = res_last_o ? 8'd0 : rj_q + 8'd1;
        if (res_last_o) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    ready_o = state_q == S_IDLE || state_q == S_CONF;
    data_v_o = (state_q == S_SER && ser_v) || state_q == S_PAD;
    data_o = state_q == S_PAD ? 8'h00 : ser_byte;
    data_idx_o = idx_q;
    block_first_o = data_v_o && first_q;
    // rem + idx is the remaining count as it stood at the start of this block
    block_last_o = data_v_o && (rem_q + TW'(idx_q)) <= TW'(BLOCK_BYTES);
    res_valid_o = state_q == S_RESULT;
    res_last_o = res_valid_o && rj_q == nn_q - 8'd1;
    res_data_o = dig_q[8*rj_q +: 8];
    kk_o = kk_q[6:0];
    nn_o = nn_q[6:0];
    ll_o = ll_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      kk_q <= '0;
      nn_q <= '0;
      ll_q <= '0;
      cfg_q <= '0;
      rem_q <= '0;
      idx_q <= '0;
      first_q <= 1'b0;
      dig_q <= '0;
      rj_q <= '0;
    end else begin
      kk_q <= kk_d;
      nn_q <= nn_d;
      ll_q <= ll_d;
      cfg_q <= cfg_d;
      rem_q <= rem_d;
      idx_q <= idx_d;
      first_q <= first_d;
      dig_q <= dig_d;
      rj_q <= rj_d;
    end
  end
endmodule

// File: tb/tb_hash_stream_intf.sv
// tb_hash_stream_intf: directed stimulus against a stream-level model of block bytes and digest readback
module tb_hash_stream_intf;
  localparam int BB = 4, BLK = 64, NNM = 32, LLW = 64;
  typedef struct packed {logic [7:0] d; logic [5:0] i; logic f; logic l;} ex_t;
  logic clk = 1'b0, reset = 1'b1, valid_i = 1'b0, res_ready_i = 1'b0, hash_finished_i = 1'b0;
  logic ready_o, res_valid_o, res_last_o, data_v_o, block_first_o, block_last_o;
  logic [1:0] cmd_i = 2'd0;
  logic [8*BB-1:0] data_i = '0;
  logic [7:0] res_data_o, data_o;
  logic [6:0] kk_o, nn_o;
  logic [LLW-1:0] ll_o;
  logic [5:0] data_idx_o;
  logic [8*NNM-1:0] hash_i;
  ex_t exq[$];
  ex_t e;
  logic [7:0] rq[$];
  logic [7:0] obs[$];
  logic [7:0] robs[$];
  logic [7:0] m[$];
  int total = 0, bad = 0;
  hash_stream_intf #(.BUS_BYTES(BB), .BLOCK_BYTES(BLK), .NN_MAX(NNM), .LL_W(LLW)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o), .cmd_i(cmd_i), .data_i(data_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_last_o(res_last_o),
    .kk_o(kk_o), .nn_o(nn_o), .ll_o(ll_o), .data_v_o(data_v_o), .data_o(data_o), .data_idx_o(data_idx_o),
    .block_first_o(block_first_o), .block_last_o(block_last_o), .hash_finished_i(hash_finished_i), .hash_i(hash_i)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #2 res_ready_i = ~res_ready_i;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    if (data_v_o) begin
      obs.push_back(data_o);
      if (exq.size() == 0) chk("extra_byte", 1, 0);
      else begin
        e = exq.pop_front();
        chk("data", data_o, e.d);
        chk("idx", data_idx_o, e.i);
        chk("first", block_first_o, e.f);
        chk("last", block_last_o, e.l);
      end
    end
    if (res_valid_o && res_ready_i) begin
      robs.push_back(res_data_o);
      if (rq.size() == 0) chk("extra_res", 1, 0);
      else begin
        chk("res_last", res_last_o, rq.size() == 1);
        chk("res_data", res_data_o, rq.pop_front());
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] c, input logic [31:0] d);
    int n = 0;
    valid_i = 1'b1;
    cmd_i = c;
    data_i = d;
    while (!ready_o && n < 2000) begin
      step(1);
      n++;
    end
    if (!ready_o) chk("ready_timeout", 0, 1);
    step(1);
    valid_i = 1'b0;
  endtask
  task automatic conf(input int kk, input int nn, input logic [63:0] ll);
    logic [7:0] b[12];
    b[0] = 8'(kk);
    b[1] = 8'(nn);
    for (int i = 0; i < 8; i++) b[2+i] = ll[8*i +: 8];
    b[10] = 8'hEE;
    b[11] = 8'hEE;
    for (int k = 0; k < 3; k++) send(2'd0, {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]});
  endtask
  task automatic model(input int kk, input int ll, input logic [7:0] msg[$]);
    int t, nb;
    ex_t x;
    t = ll + ((kk != 0) ? BLK : 0);
    nb = (t == 0) ? 1 : (t + BLK - 1) / BLK;
    for (int k = 0; k < nb * BLK; k++) begin
      x.d = (k < t) ? msg[k] : 8'h00;
      x.i = 6'(k % BLK);
      x.f = k < BLK;
      x.l = k >= (nb - 1) * BLK;
      exq.push_back(x);
    end
  endtask
  task automatic stream(input logic [7:0] msg[$], input int n, input int skip);
    logic [31:0] w;
    for (int k = skip; k < n; k += 4) begin
      for (int j = 0; j < 4; j++) w[8*j +: 8] = (k + j < msg.size()) ? msg[k+j] : 8'hCC;
      send(2'd1, w);
    end
  endtask
  task automatic drain();
    int n = 0;
    while (exq.size() != 0 && n < 3000) begin
      step(1);
      n++;
    end
    chk("stream_drain", exq.size(), 0);
    step(2);
    chk("wait_hash_ready", ready_o, 0);
  endtask
  task automatic result(input int nn);
    int n = 0;
    robs.delete();
    for (int j = 0; j < nn; j++) rq.push_back(8'(j));
    hash_finished_i = 1'b1;
    step(1);
    hash_finished_i = 1'b0;
    chk("res_latency", res_valid_o, 1);
    while (rq.size() != 0 && n < 500) begin
      step(1);
      n++;
    end
    chk("res_drain", rq.size(), 0);
    step(1);
    chk("res_idle_ready", ready_o, 1);
    chk("res_idle_valid", res_valid_o, 0);
  endtask
  task automatic mk_msg(input int n);
    m.delete();
    for (int k = 0; k < n; k++) m.push_back(8'(k * 7 + 1));
  endtask
  initial begin
    int cnt;
    for (int j = 0; j < NNM; j++) hash_i[8*j +: 8] = 8'(j);
    step(3);
    chk("rst_ready", ready_o, 1);
    chk("rst_data_v", data_v_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_res_last", res_last_o, 0);
    chk("rst_first", block_first_o, 0);
    chk("rst_last", block_last_o, 0);
    chk("rst_kk", kk_o, 0);
    chk("rst_nn", nn_o, 0);
    chk("rst_ll", ll_o, 0);
    chk("rst_idx", data_idx_o, 0);
    reset = 1'b0;
    step(1);
    m = '{8'h61, 8'h62, 8'h63};
    obs.delete();
    model(0, 3, m);
    conf(0, 32, 3);
    chk("t1_nn", nn_o, 32);
    chk("t1_ll", ll_o, 3);
    m.push_back(8'h64);
    stream(m, 4, 0);
    drain();
    chk("t1_count", obs.size(), 64);
    chk("t1_b0", obs[0], 8'h61);
    chk("t1_b2", obs[2], 8'h63);
    chk("t1_b3", obs[3], 8'h00);
    chk("t1_b63", obs[63], 8'h00);
    result(32);
    chk("t1_r_count", robs.size(), 32);
    chk("t1_r0", robs[0], 8'h00);
    chk("t1_r31", robs[31], 8'h1F);
    obs.delete();
    m.delete();
    model(0, 0, m);
    conf(0, 4, 0);
    chk("t2_nn", nn_o, 4);
    drain();
    chk("t2_count", obs.size(), 64);
    result(4);
    obs.delete();
    mk_msg(130);
    model(0, 130, m);
    conf(0, 8, 130);
    stream(m, 4, 0);
    cnt = 0;
    while (!ready_o && cnt < 20) begin
      step(1);
      cnt++;
    end
    chk("t3_ready_low", cnt, 4);
    stream(m, 130, 4);
    drain();
    chk("t3_count", obs.size(), 192);
    result(8);
    obs.delete();
    mk_msg(128);
    model(16, 64, m);
    conf(16, 0, 64);
    chk("t4_kk", kk_o, 16);
    chk("t4_nn_clamp", nn_o, 32);
    stream(m, 128, 0);
    drain();
    chk("t4_count", obs.size(), 128);
    result(32);
    conf(100, 5, 0);
    chk("t5_kk_clamp", kk_o, 32);
    chk("t5_nn", nn_o, 5);
    send(2'd3, 32'h0);
    send(2'd1, 32'h11223344);
    step(6);
    chk("t5_abort_ready", ready_o, 1);
    chk("t5_abort_kk_kept", kk_o, 32);
    mk_msg(40);
    model(0, 40, m);
    conf(0, 32, 40);
    stream(m, 20, 0);
    step(1);
    chk("t6_idx17_v", data_v_o, 1);
    chk("t6_idx17", data_idx_o, 17);
    reset = 1'b1;
    exq.delete();
    step(1);
    reset = 1'b0;
    chk("t6_data_v", data_v_o, 0);
    chk("t6_ready", ready_o, 1);
    chk("t6_idx", data_idx_o, 0);
    chk("t6_ll", ll_o, 0);
    hash_finished_i = 1'b1;
    step(1);
    hash_finished_i = 1'b0;
    step(3);
    chk("t6_hash_ignored", res_valid_o, 0);
    chk("t6_still_idle", ready_o, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
